// File: rtl/fp_pkg.sv
// Shared mantissa-width constants and divider state encoding for the FP datapath.
package fp_pkg;

    localparam int MANT_W = 24;
    localparam int PROD_W = 2 * MANT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/mantissa_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then trial-subtract the divisor.
module div_step
    import fp_pkg::*;
#(
    parameter int W = MANT_W
) (
    input  logic [W:0]   rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W:0]   rem_o,
    output logic         q_o
);

    logic [W+1:0] trial;
    logic [W:0]   diff;

    // The incoming remainder is always below the divisor, so the shifted trial value
    // is below twice the divisor and the restored result fits back into W+1 bits.
    always_comb begin
        trial = {rem_i, bit_i};
        diff  = trial[W:0] - {1'b0, divisor_i};
        q_o   = (trial >= {2'b00, divisor_i});
        rem_o = q_o ? diff : trial[W:0];
    end

endmodule

// File: rtl/mantissa_divider.sv
// Sequential radix-2 restoring mantissa divider: 48-bit dividend / 24-bit divisor, one quotient bit per cycle.
module mantissa_divider #(
    parameter int MANT_W = fp_pkg::MANT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*MANT_W-1:0]   r_op,
    input  logic [MANT_W-1:0]     b_op,
    output logic                  busy,
    output logic                  done,
    output logic [MANT_W-1:0]     q_op,
    output logic [MANT_W-1:0]     rem_op,
    output logic                  ovf
);

    import fp_pkg::*;

    div_state_e        state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [MANT_W:0]   partRem_q, partRem_d;
    logic [MANT_W-1:0] dividend_q, dividend_d;
    logic [MANT_W-1:0] divisor_q, divisor_d;
    logic [MANT_W-1:0] quo_q, quo_d;
    logic [MANT_W-1:0] q_q, q_d;
    logic [MANT_W-1:0] rem_q, rem_d;
    logic              ovf_q, ovf_d;

    logic              overflow;
    logic [MANT_W:0]   stepRem;
    logic              stepQ;

    // A quotient wider than MANT_W bits exists exactly when the upper half reaches the divisor.
    assign overflow = (r_op[2*MANT_W-1:MANT_W] >= b_op);

    div_step #(.W(MANT_W)) u_step (
        .rem_i     (partRem_q),
        .bit_i     (dividend_q[MANT_W-1]),
        .divisor_i (divisor_q),
        .rem_o     (stepRem),
        .q_o       (stepQ)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        partRem_d  = partRem_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quo_d      = quo_q;
        q_d        = q_q;
        rem_d      = rem_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (overflow) begin
                        state_d = DONE;
                        q_d     = '1;
                        rem_d   = '0;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d    = RUN;
                        cnt_d      = 5'(MANT_W - 1);
                        partRem_d  = {1'b0, r_op[2*MANT_W-1:MANT_W]};
                        dividend_d = r_op[MANT_W-1:0];
                        divisor_d  = b_op;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                partRem_d  = stepRem;
                dividend_d = dividend_q << 1;
                quo_d      = {quo_q[MANT_W-2:0], stepQ};
                // Results are published only on entry to DONE so they stay stable throughout RUN.
                if (cnt_q == 5'd0) begin
                    state_d = DONE;
                    q_d     = {quo_q[MANT_W-2:0], stepQ};
                    rem_d   = stepRem[MANT_W-1:0];
                    ovf_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            partRem_q  <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quo_q      <= '0;
            q_q        <= '0;
            rem_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            partRem_q  <= partRem_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quo_q      <= quo_d;
            q_q        <= q_d;
            rem_q      <= rem_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign q_op   = q_q;
    assign rem_op = rem_q;
    assign ovf    = ovf_q;

endmodule
